// File: rtl/conv_inst_sequencer_pkg.sv
// Shared constants for the convolution instruction sequencer.
// Covers the instruction-word bit positions, the idle word and the FSM state type.
package conv_inst_sequencer_pkg;

    localparam int unsigned KSize = 3;
    localparam int unsigned AddrW = 11;
    localparam int unsigned CntW  = 16;

    localparam int unsigned BitSfuPass = 34;
    localparam int unsigned BitAcc     = 33;
    localparam int unsigned BitCenPmem = 32;
    localparam int unsigned BitWenPmem = 31;
    localparam int unsigned BitAPmemLo = 20;
    localparam int unsigned BitCenXmem = 19;
    localparam int unsigned BitAXmemLo = 7;
    localparam int unsigned BitOfifoRd = 6;
    localparam int unsigned BitL0Rd    = 3;
    localparam int unsigned BitL0Wr    = 2;
    localparam int unsigned BitExecute = 1;
    localparam int unsigned BitLoad    = 0;

    // Both memories disabled, xmem in read mode; every other field inactive.
    localparam logic [63:0] DefaultInst = 64'h0000_0001_000C_0000;

    typedef enum logic [3:0] {
        StIdle,
        StWaitW,
        StWL0,
        StWLoad,
        StGap,
        StExec,
        StDrain,
        StNext,
        StDone
    } state_e;

endpackage

// File: rtl/conv_inst_sequencer_onij_mapper.sv
// Maps the input pixel being drained to its output-pixel PSUM address for the current kernel tap.
// Holds the pixel (nx, ny) and tap (kx, ky) counters; the parent decides when they step.
module conv_inst_sequencer_onij_mapper
    import conv_inst_sequencer_pkg::*;
#(
    parameter int unsigned in_w  = 6,
    parameter int unsigned out_w = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_nij,
    input  logic             step_nij,
    input  logic             clear_k,
    input  logic             step_k,
    output logic [AddrW-1:0] onij,
    output logic             onij_valid
);

    localparam int unsigned CW = $clog2(in_w);

    logic [CW-1:0] nx;
    logic [CW-1:0] ny;
    logic [1:0]    kx;
    logic [1:0]    ky;
    logic [CW-1:0] dx;
    logic [CW-1:0] dy;
    logic          vx;
    logic          vy;

    always_ff @(posedge clk) begin
        if (reset || clear_nij) begin
            nx <= '0;
            ny <= '0;
        end else if (step_nij) begin
            if (nx == CW'(in_w - 1)) begin
                nx <= '0;
                ny <= (ny == CW'(in_w - 1)) ? '0 : ny + 1'b1;
            end else begin
                nx <= nx + 1'b1;
            end
        end
    end

    // kij is tracked as (kx, ky) so no divide-by-3 is ever needed.
    always_ff @(posedge clk) begin
        if (reset || clear_k) begin
            kx <= '0;
            ky <= '0;
        end else if (step_k) begin
            if (kx == 2'(KSize - 1)) begin
                kx <= '0;
                ky <= (ky == 2'(KSize - 1)) ? '0 : ky + 1'b1;
            end else begin
                kx <= kx + 1'b1;
            end
        end
    end

    always_comb begin
        dx         = nx - CW'(kx);
        dy         = ny - CW'(ky);
        vx         = (nx >= CW'(kx)) && (dx < CW'(out_w));
        vy         = (ny >= CW'(ky)) && (dy < CW'(out_w));
        onij_valid = vx && vy;
        onij       = '0;
        if (onij_valid) begin
            onij = AddrW'(dx) + AddrW'(dy) * AddrW'(out_w);
        end
    end

endmodule

// File: rtl/conv_inst_sequencer.sv
// Generates the core instruction word for a full 3x3 convolution tile (nine kij passes).
// Each pass: weights to L0, load PEs, gap, execute activations, drain OFIFO into PSUM SRAM.
module conv_inst_sequencer
    import conv_inst_sequencer_pkg::*;
#(
    parameter int unsigned row           = 8,
    parameter int unsigned col           = 8,
    parameter int unsigned len_nij       = 36,
    parameter int unsigned in_w          = 6,
    parameter int unsigned out_w         = 4,
    parameter int unsigned w_base        = 1024,
    parameter int unsigned gap_cycles    = 10,
    parameter int unsigned drain_timeout = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        w_ready,
    input  logic        ofifo_valid,
    output logic [63:0] inst,
    output logic [3:0]  kij_cur,
    output logic        busy,
    output logic        done,
    output logic        err_timeout
);

    state_e            state;
    logic [CntW-1:0]   cnt;
    logic [CntW-1:0]   nij;
    logic [CntW-1:0]   nij_next;
    logic [3:0]        kij;
    logic [63:0]       word;
    logic              rd_fire;
    logic              drained;
    logic              start_acc;
    logic [AddrW-1:0]  onij;
    logic              onij_valid;

    assign kij_cur   = kij;
    assign start_acc = (state == StIdle) && start;

    conv_inst_sequencer_onij_mapper #(
        .in_w  (in_w),
        .out_w (out_w)
    ) u_onij_mapper (
        .clk        (clk),
        .reset      (reset),
        .clear_nij  (start_acc || (state == StNext)),
        .step_nij   (rd_fire),
        .clear_k    (start_acc),
        .step_k     (state == StNext),
        .onij       (onij),
        .onij_valid (onij_valid)
    );

    always_comb begin
        rd_fire  = ((state == StExec) || (state == StDrain)) && ofifo_valid &&
                   (nij != CntW'(len_nij));
        nij_next = rd_fire ? nij + 1'b1 : nij;
        drained  = (nij_next == CntW'(len_nij));

        word = DefaultInst;
        unique case (state)
            StWL0: begin
                word[BitAXmemLo +: AddrW] = AddrW'(w_base + 32'(cnt));
                if (cnt < CntW'(col)) word[BitCenXmem] = 1'b0;
                if (cnt != '0)        word[BitL0Wr]    = 1'b1;
            end
            StWLoad: begin
                word[BitL0Rd] = 1'b1;
                if (cnt != '0) word[BitLoad] = 1'b1;
            end
            StExec: begin
                word[BitAXmemLo +: AddrW] = AddrW'(cnt);
                if (cnt < CntW'(len_nij)) word[BitCenXmem] = 1'b0;
                word[BitL0Wr] = 1'b1;
                word[BitL0Rd] = 1'b1;
                if (cnt != '0) word[BitExecute] = 1'b1;
            end
            default: ;
        endcase

        // Out-of-window pixels are still popped, but leave PSUM untouched.
        if (rd_fire) begin
            word[BitOfifoRd] = 1'b1;
            word[BitSfuPass] = (kij == 4'd0);
            word[BitAcc]     = (kij != 4'd0);
            if (onij_valid) begin
                word[BitCenPmem]              = 1'b0;
                word[BitWenPmem]              = 1'b1;
                word[BitAPmemLo +: AddrW]     = onij;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            cnt         <= '0;
            nij         <= '0;
            kij         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            inst        <= DefaultInst;
        end else begin
            inst <= word;
            done <= 1'b0;
            nij  <= nij_next;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        kij         <= '0;
                        nij         <= '0;
                        err_timeout <= 1'b0;
                        busy        <= 1'b1;
                        state       <= StWaitW;
                    end
                end
                StWaitW: begin
                    cnt <= '0;
                    if (w_ready) state <= StWL0;
                end
                StWL0: begin
                    if (cnt == CntW'(col)) begin
                        cnt   <= '0;
                        state <= StWLoad;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StWLoad: begin
                    if (cnt == CntW'(col + row)) begin
                        cnt   <= '0;
                        state <= StGap;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StGap: begin
                    if (cnt == CntW'(gap_cycles - 1)) begin
                        cnt   <= '0;
                        state <= StExec;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StExec: begin
                    if (cnt == CntW'(len_nij)) begin
                        cnt   <= '0;
                        state <= StDrain;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StDrain: begin
                    if (drained) begin
                        cnt   <= '0;
                        state <= StNext;
                    end else if (cnt == CntW'(drain_timeout - 1)) begin
                        cnt         <= '0;
                        err_timeout <= 1'b1;
                        state       <= StNext;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StNext: begin
                    kij <= kij + 1'b1;
                    nij <= '0;
                    if (kij == 4'(KSize * KSize - 1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        state <= StWaitW;
                    end
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_inst_sequencer.sv
// Bench for conv_inst_sequencer: OFIFO model plus PSUM-write scoreboard, a table of
// hand-derived PSUM mappings, and directed timeout / reset sequences.
`timescale 1ns/1ps
module tb_conv_inst_sequencer;

    localparam logic [63:0] DEF = 64'h0000_0001_000C_0000;
    localparam int LAT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        w_ready;
    logic        ofifo_valid;
    logic [63:0] inst;
    logic [3:0]  kij_cur;
    logic        busy;
    logic        done;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    conv_inst_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .w_ready     (w_ready),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .kij_cur     (kij_cur),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout)
    );

    typedef struct {
        int kij;
        int nij;
        bit cen;
        int a;
        bit acc;
        bit sfu;
    } vec_t;

    typedef struct {
        int          kij;
        int          nij;
        logic [15:0] e;
    } sb_t;

    vec_t        tbl [10];
    logic [15:0] obs [9][36];
    int          writes [9];
    int          rq [$];
    sb_t         sb [$];
    int          waddr [$];
    int          m_kij = 0;
    int          m_nij = 0;
    int          load_cnt = 0;
    int          done_cnt = 0;
    bit          mon_en = 1'b0;
    logic [63:0] prev_inst;
    logic        prev_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected inst[35:20] for a drained pixel.
    function automatic logic [15:0] exp_pmem(input int kij, input int nij);
        int          ox;
        int          oy;
        logic [15:0] e;
        ox = (nij % 6) - (kij % 3);
        oy = (nij / 6) - (kij / 3);
        e = 16'h0;
        e[14] = (kij == 0);
        e[13] = (kij != 0);
        if (ox >= 0 && ox < 4 && oy >= 0 && oy < 4) begin
            e[11]   = 1'b1;
            e[10:0] = 11'(ox + oy * 4);
        end else begin
            e[12] = 1'b1;
        end
        return e;
    endfunction

    task automatic monitor();
        sb_t s;
        if (sb.size() > 0) begin
            s = sb.pop_front();
            chk("ofifo_rd", 64'(inst[6]), 64'd1);
            chk("pmem_fields", 64'(inst[35:20]), 64'(s.e));
            if (s.kij < 9) begin
                obs[s.kij][s.nij] = inst[35:20];
                if (!inst[32]) writes[s.kij]++;
            end
        end else begin
            chk("no_read_pmem", 64'({inst[6], inst[35:20]}), 64'({1'b0, 16'h1000}));
        end
        if (inst[1]) rq.push_back(cyc + LAT);
        if (!inst[19] && inst[17:7] >= 11'd1024) waddr.push_back(int'(inst[17:7]));
        if (!prev_inst[19] && prev_inst[17:7] == 11'd1024) begin
            chk("l0_wr_first", 64'(prev_inst[2]), 64'd0);
            chk("l0_wr_second", 64'(inst[2]), 64'd1);
        end
        if (inst[0]) load_cnt++;
        if (done) begin
            done_cnt++;
            chk("done_busy", 64'(busy), 64'd0);
            chk("busy_before_done", 64'(prev_busy), 64'd1);
            chk("done_kij", 64'(kij_cur), 64'd9);
            chk("done_err", 64'(err_timeout), 64'd0);
        end
        // OFIFO model: a row becomes readable LAT cycles after its execute is seen.
        if (rq.size() > 0 && rq[0] <= cyc) begin
            rq.delete(0);
            ofifo_valid = 1'b1;
            s.kij = m_kij;
            s.nij = m_nij;
            s.e   = exp_pmem(m_kij, m_nij);
            sb.push_back(s);
            m_nij++;
            if (m_nij == 36) begin
                m_nij = 0;
                m_kij++;
            end
        end else begin
            ofifo_valid = 1'b0;
        end
        prev_inst = inst;
        prev_busy = busy;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (mon_en) monitor();
    endtask

    initial begin
        int   last_ex;
        int   err_cyc;
        bit   seen;
        logic [15:0] o;

        tbl[0] = '{kij: 4, nij: 7,  cen: 0, a: 0,  acc: 1, sfu: 0};
        tbl[1] = '{kij: 4, nij: 0,  cen: 1, a: 0,  acc: 1, sfu: 0};
        tbl[2] = '{kij: 4, nij: 35, cen: 1, a: 0,  acc: 1, sfu: 0};
        tbl[3] = '{kij: 0, nij: 0,  cen: 0, a: 0,  acc: 0, sfu: 1};
        tbl[4] = '{kij: 0, nij: 3,  cen: 0, a: 3,  acc: 0, sfu: 1};
        tbl[5] = '{kij: 0, nij: 4,  cen: 1, a: 0,  acc: 0, sfu: 1};
        tbl[6] = '{kij: 0, nij: 6,  cen: 0, a: 4,  acc: 0, sfu: 1};
        tbl[7] = '{kij: 0, nij: 21, cen: 0, a: 15, acc: 0, sfu: 1};
        tbl[8] = '{kij: 8, nij: 14, cen: 0, a: 0,  acc: 1, sfu: 0};
        tbl[9] = '{kij: 8, nij: 35, cen: 0, a: 15, acc: 1, sfu: 0};
        for (int k = 0; k < 9; k++) begin
            writes[k] = 0;
            for (int n = 0; n < 36; n++) obs[k][n] = 16'h0;
        end

        reset = 1'b1;
        start = 1'b0;
        w_ready = 1'b0;
        ofifo_valid = 1'b0;
        repeat (3) step();
        chk("rst_inst", inst, DEF);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_kij", 64'(kij_cur), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);

        // start together with reset: reset wins
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("start_under_reset", 64'(busy), 64'd0);
        reset = 1'b0;
        repeat (2) step();
        chk("idle_inst", inst, DEF);

        // Full nine-pass run with the OFIFO model
        w_ready = 1'b1;
        prev_inst = inst;
        prev_busy = busy;
        mon_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
            start = (i == 300);  // must be ignored while busy
            step();
        end
        start = 1'b0;
        chk("run_completed", 64'(done_cnt), 64'd1);
        repeat (20) step();
        mon_en = 1'b0;
        ofifo_valid = 1'b0;
        chk("done_once", 64'(done_cnt), 64'd1);
        chk("reads_total", 64'(m_kij * 36 + m_nij), 64'd324);
        chk("load_cycles", 64'(load_cnt), 64'd144);
        chk("wl0_addr_count", 64'(waddr.size()), 64'd72);
        for (int i = 0; i < waddr.size(); i++) chk("wl0_addr", 64'(waddr[i]), 64'(1024 + i % 8));
        for (int k = 0; k < 9; k++) chk("writes_per_pass", 64'(writes[k]), 64'd16);
        for (int i = 0; i < 10; i++) begin
            o = obs[tbl[i].kij][tbl[i].nij];
            chk("tbl_cen", 64'(o[12]), 64'(tbl[i].cen));
            chk("tbl_wen", 64'(o[11]), 64'(!tbl[i].cen));
            if (!tbl[i].cen) chk("tbl_a_pmem", 64'(o[10:0]), 64'(tbl[i].a));
            chk("tbl_acc", 64'(o[13]), 64'(tbl[i].acc));
            chk("tbl_sfu", 64'(o[14]), 64'(tbl[i].sfu));
        end
        chk("after_run_busy", 64'(busy), 64'd0);
        chk("after_run_inst", inst, DEF);

        // Drain timeout: OFIFO never valid
        start = 1'b1;
        step();
        start = 1'b0;
        last_ex = -1;
        err_cyc = -1;
        for (int i = 0; i < 400 && err_cyc < 0; i++) begin
            step();
            if (inst[1]) last_ex = cyc;
            if (err_timeout) err_cyc = cyc;
        end
        chk("timeout_seen", 64'(err_cyc >= 0), 64'd1);
        chk("timeout_delay", 64'(err_cyc - last_ex), 64'd64);
        for (int i = 0; i < 300 && !inst[1]; i++) step();
        chk("second_pass_exec", 64'(inst[1]), 64'd1);
        chk("err_sticky", 64'(err_timeout), 64'd1);
        chk("second_pass_kij", 64'(kij_cur), 64'd1);

        // Reset mid-EXEC
        reset = 1'b1;
        step();
        chk("midreset_inst", inst, DEF);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_kij", 64'(kij_cur), 64'd0);
        chk("midreset_err", 64'(err_timeout), 64'd0);
        reset = 1'b0;
        repeat (15) step();
        chk("idle_hold_inst", inst, DEF);
        chk("idle_hold_busy", 64'(busy), 64'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_busy", 64'(busy), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            step();
            seen = !inst[19] && (inst[17:7] == 11'd1024);
        end
        chk("restart_wl0", 64'(seen), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_inst_sequencer.md
Name: conv_inst_sequencer

Overview:
- Hardware controller that generates the core's 64-bit instruction word, which the core decodes.
- Sequences one full 3x3 convolution tile: for each kij 0..8 it moves weights SRAM -> L0, loads them into the PEs, streams the activations, and drains the OFIFO into PSUM SRAM using output-nij address mapping.
- Sits directly in front of the core's inst input. A host pre-loads activations at xmem 0..len_nij-1 and weights for the current kij at xmem w_base.. before each pass.

Parameters:
row, 8, PE array rows
col, 8, PE array columns
len_nij, 36, input pixels per channel tile (in_w*in_w)
in_w, 6, input feature-map width
out_w, 4, output feature-map width (in_w-2)
w_base, 1024, xmem base address of weights
gap_cycles, 10, idle cycles between PE load and execute
drain_timeout, 64, maximum cycles spent in DRAIN

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a 9-kij run; ignored while busy
w_ready  in  1  host has loaded the weights for the current kij; sampled in WAIT_W
ofifo_valid  in  1  OFIFO holds a complete row
inst  out  64  instruction word to the core (registered)
kij_cur  out  4  kij currently being processed
busy  out  1  high from start acceptance until DONE
done  out  1  one-cycle pulse at run completion
err_timeout  out  1  sticky until next start; DRAIN exceeded drain_timeout

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- inst field map:
  - [63] debug=0; [62:36]=0
  - [35] REN_pmem, [34] sfu_passthrough, [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
  - [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
  - [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- Default word: CEN_xmem=1, WEN_xmem=1, CEN_pmem=1; all other bits 0 (=64'h0000_0001_000C_0000).
- Reset values: inst=default, state IDLE, kij_cur=0, busy=0, done=0, err_timeout=0.
- Reset mid-operation aborts immediately to these values.
- inst is registered: the word for state cycle n appears on cycle n+1.
- FSM transitions: IDLE -> WAIT_W -> W_L0 -> W_LOAD -> GAP -> EXEC -> DRAIN -> NEXT -> (WAIT_W | DONE) -> IDLE.
- IDLE: on start, clear kij and err_timeout, set busy, go to WAIT_W.
- WAIT_W: drive the default word until w_ready=1.
- W_L0 (col+1 cycles):
  - cycle 0: CEN_xmem=0, A_xmem=w_base, l0_wr=0.
  - cycles 1..col: l0_wr=1. A_xmem=w_base+i with CEN_xmem=0 for i<col; on cycle col, CEN_xmem=1.
- W_LOAD (col+row+1 cycles):
  - cycle 0: l0_rd=1.
  - cycles 1..col+row: l0_rd=1, load=1.
- GAP: gap_cycles cycles of the default word.
- EXEC (len_nij+1 cycles):
  - cycle 0: CEN_xmem=0, A_xmem=0, l0_wr=1, l0_rd=1.
  - cycles i=1..len_nij: A_xmem=i (CEN_xmem=1 at i=len_nij), l0_wr=1, l0_rd=1, execute=1.
- Drain logic, active in EXEC and DRAIN on every cycle with ofifo_valid=1:
  - Assert ofifo_rd=1 and increment the nij counter.
  - Track (nx,ny) as counters that wrap at in_w; no divider.
  - onx=nx-kx, ony=ny-ky, where kx=kij%3 and ky=kij/3 are held as counters.
  - If 0<=onx<out_w and 0<=ony<out_w: CEN_pmem=0, WEN_pmem=1, A_pmem=onx+ony*out_w. Otherwise CEN_pmem=1 and WEN_pmem=0.
  - kij==0: sfu_passthrough=1, acc=0. Otherwise sfu_passthrough=0, acc=1.
- DRAIN:
  - Ends when the nij counter reaches len_nij, going to NEXT.
  - If drain_timeout cycles elapse first, set err_timeout and go to NEXT anyway.
  - ofifo_valid=0 in a cycle leaves the PMEM fields at default.
- NEXT: one cycle. kij_cur++; if the new kij==9, go to DONE, else go to WAIT_W. Clear the nij counters.
- DONE: pulse done=1 for one cycle, busy=0, go to IDLE.
- start during busy is ignored. start and reset together: reset wins.

Decomposition:
- Shared package: inst bit-position constants, default-word constant, FSM state enum, kernel size 3.
- One sub-module, onij_mapper: holds nx/ny/kx/ky counters and outputs onij plus a valid flag. Combinational on the counters; counters are stepped by the parent.

Test Plan:
- Reset -> inst=64'h0000_0001_000C_0000, busy=0, done=0, kij_cur=0.
- start with w_ready=1 -> W_L0 presents A_xmem 1024..1031; l0_wr rises exactly one cycle after CEN_xmem first goes low; load is high for exactly 16 cycles.
- kij=4, stream ofifo_valid=1 continuously:
  - nij=7 -> A_pmem=0, CEN_pmem=0, acc=1.
  - nij=0 -> CEN_pmem=1.
  - nij=35 -> CEN_pmem=1.
  - exactly 16 writes per pass.
- kij=0 pass -> sfu_passthrough=1 and acc=0 on all 16 writes, A_pmem sequence 0..15 in order.
- Full run with an ofifo model of latency row+col -> 9 passes, done pulses once, err_timeout=0, busy falls with done.
- ofifo_valid held 0 -> err_timeout=1 after 64 DRAIN cycles; reset asserted mid-EXEC -> default inst on the next cycle and state IDLE.
